// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: scan FSM encoding, polarity and
// default timing constants used by the display tops.
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StGap
  } scan_state_e;

  // Segment lines on the board are active-low; hex_7seg applies this at its output.
  localparam logic SegActiveLow = 1'b1;

  localparam int unsigned DefDwellCycles = 50000;
  localparam int unsigned DefGapCycles   = 500;
  localparam int unsigned DefBlinkFrames = 64;

endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable down-counter; tc is high while the count sits at zero. Reused for dwell and gap.
module seg_dwell_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             tc
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller: latches a hex value through a ready/load handshake and
// walks a shared nibble bus across the digits with blanking, blink and inter-digit dark gaps.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    zblank_en,
  input  logic                    blink_en,
  output logic                    ready,
  output logic [3:0]              hex,
  output logic                    seg_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  import seg_pkg::*;

  localparam int unsigned VW     = 4 * NUM_DIGITS;
  localparam int unsigned DigW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntMax = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BlkW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [DigW-1:0] LastDig = DigW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] DwellLd = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] GapLd   = CntW'(GAP_CYCLES - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_FRAMES - 1);

  scan_state_e           state_q, state_d;
  logic [DigW-1:0]       digit_q, digit_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [BlkW-1:0]       bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] dsel_q, dsel_d;
  logic [3:0]            hex_q, hex_d;
  logic                  seg_q, seg_d;

  logic          tc;
  logic          advance;
  logic          accept;
  logic          boundary;
  logic [VW-1:0] upper;

  assign accept   = load && !pending_q;
  assign boundary = (state_q == StGap) && tc && (digit_q == LastDig);

  seg_dwell_timer #(
    .Width (CntW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (advance),
    .load_val ((state_d == StScan) ? DwellLd : GapLd),
    .tc       (tc)
  );

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StScan;
          digit_d = '0;
          advance = 1'b1;
        end
      end
      StScan: begin
        if (tc) begin
          state_d = StGap;
          advance = 1'b1;
        end
      end
      StGap: begin
        if (tc) begin
          state_d = StScan;
          digit_d = (digit_q == LastDig) ? '0 : digit_q + 1'b1;
          advance = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The shadow value and blink phase only move on the frame boundary, so a frame never tears.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    if (accept) begin
      if (state_q == StIdle) begin
        active_d = value;
      end else begin
        shadow_d  = value;
        pending_d = 1'b1;
      end
    end
    if (boundary) begin
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (bcnt_q == BlkLast) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  assign upper = active_d >> {digit_d, 2'b00};

  // Display outputs are recomputed only on state entry and held for the whole dwell.
  always_comb begin
    dsel_d = dsel_q;
    hex_d  = hex_q;
    seg_d  = seg_q;
    if (advance) begin
      dsel_d = '0;
      hex_d  = '0;
      seg_d  = 1'b0;
      if (state_d == StScan) begin
        dsel_d = NUM_DIGITS'(1) << digit_d;
        hex_d  = upper[3:0];
        seg_d  = !(blink_en && !phase_d) && !(zblank_en && (digit_d != '0) && (upper == '0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      digit_q   <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bcnt_q    <= '0;
      phase_q   <= 1'b1;
      dsel_q    <= '0;
      hex_q     <= '0;
      seg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      dsel_q    <= dsel_d;
      hex_q     <= hex_d;
      seg_q     <= seg_d;
    end
  end

  assign ready      = !pending_q;
  assign hex        = hex_q;
  assign seg_en     = seg_q;
  assign digit_sel  = dsel_q;
  assign frame_done = boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a short scan (N=4, dwell 4, gap 1, blink 2).
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int GP    = 1;
  localparam int BF    = 2;
  localparam int SLOT  = DW + GP;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        zblank_en;
  logic        blink_en;
  logic        ready;
  logic [3:0]  hex;
  logic        seg_en;
  logic [3:0]  digit_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DW),
    .GAP_CYCLES   (GP),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .zblank_en  (zblank_en),
    .blink_en   (blink_en),
    .ready      (ready),
    .hex        (hex),
    .seg_en     (seg_en),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] dsel;
    logic [3:0] hex;
    logic       seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  typedef struct packed {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dsel;
    logic [3:0]  hex;
    logic        seg;
    logic        fd;
  } vec_t;

  exp_t sb_q[$];
  vec_t tv[21];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position within the frame rather than an explicit state machine.
  bit          m_run;
  int          m_pos;
  logic [15:0] m_active, m_shadow;
  bit          m_pending;
  int          m_bcnt;
  bit          m_phase;
  logic [3:0]  m_dsel, m_hex;
  bit          m_seg;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_active = '0; m_shadow = '0; m_pending = 0;
    m_bcnt = 0; m_phase = 1; m_dsel = '0; m_hex = '0; m_seg = 0;
  endtask

  task automatic model_latch(input logic zb, input logic bl);
    int d, w;
    d = m_pos / SLOT;
    w = m_pos % SLOT;
    if (w == 0) begin
      m_dsel = 4'b0001 << d;
      m_hex  = m_active[4*d +: 4];
      m_seg  = !(bl && !m_phase) && !(zb && d != 0 && (m_active >> (4*d)) == 16'h0);
    end else if (w == DW) begin
      m_dsel = '0; m_hex = '0; m_seg = 0;
    end
  endtask

  task automatic model_step(input logic ld, input logic [15:0] val, input logic zb,
                            input logic bl);
    bit acc, bnd, oldp;
    acc = ld && !m_pending;
    if (!m_run) begin
      if (acc) begin
        m_run = 1; m_pos = 0; m_active = val;
        model_latch(zb, bl);
      end
    end else begin
      bnd  = (m_pos == FRAME - 1);
      oldp = m_pending;
      if (acc) begin
        m_shadow = val; m_pending = 1;
      end
      if (bnd) begin
        if (oldp) begin
          m_active = m_shadow; m_pending = 0;
        end
        m_bcnt++;
        if (m_bcnt == BF) begin
          m_bcnt = 0; m_phase = !m_phase;
        end
      end
      m_pos = (m_pos + 1) % FRAME;
      model_latch(zb, bl);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.dsel = m_dsel;
    e.hex  = m_hex;
    e.seg  = m_seg;
    e.fd   = m_run && (m_pos == FRAME - 1);
    e.rdy  = !m_pending;
    return e;
  endfunction

  task automatic compare(input exp_t e, input string name);
    bit bad;
    checks++;
    bad = (digit_sel !== e.dsel) || (seg_en !== e.seg) || (frame_done !== e.fd) ||
          (ready !== e.rdy) || ((e.dsel != 0) && (hex !== e.hex));
    if (bad) begin
      errors++;
      $display("FAIL %s t=%0t: got dsel=%b hex=%h seg=%b fd=%b rdy=%b, want dsel=%b hex=%h seg=%b fd=%b rdy=%b",
               name, $time, digit_sel, hex, seg_en, frame_done, ready,
               e.dsel, e.hex, e.seg, e.fd, e.rdy);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  // Drive one cycle at the negedge, queue the expectation, compare at the following negedge.
  task automatic cycle(input logic ld, input logic [15:0] val, input logic zb, input logic bl,
                       input bit use_tab, input exp_t tab, input string name);
    exp_t e;
    load = ld; value = val; zblank_en = zb; blink_en = bl;
    model_step(ld, val, zb, bl);
    sb_q.push_back(use_tab ? tab : model_out());
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    compare(e, name);
  endtask

  task automatic run(input int n, input logic zb, input logic bl, input string name);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, zb, bl, 1'b0, '0, name);
  endtask

  task automatic run_to_pos(input int pos, input logic zb, input logic bl);
    for (int i = 0; i < 2 * FRAME && m_pos != pos; i++) cycle(1'b0, 16'h0, zb, bl, 1'b0, '0, "seek");
  endtask

  initial begin
    exp_t te;

    tv[0]  = '{1'b1, 16'h12AB, 4'b0001, 4'hB, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 16'h0000, 4'b0001, 4'hB, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 16'h0000, 4'b0001, 4'hB, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 16'h0000, 4'b0001, 4'hB, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 16'h0000, 4'b0010, 4'hA, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 16'h0000, 4'b0010, 4'hA, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 16'h0000, 4'b0010, 4'hA, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 16'h0000, 4'b0010, 4'hA, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0};
    tv[10] = '{1'b0, 16'h0000, 4'b0100, 4'h2, 1'b1, 1'b0};
    tv[11] = '{1'b0, 16'h0000, 4'b0100, 4'h2, 1'b1, 1'b0};
    tv[12] = '{1'b0, 16'h0000, 4'b0100, 4'h2, 1'b1, 1'b0};
    tv[13] = '{1'b0, 16'h0000, 4'b0100, 4'h2, 1'b1, 1'b0};
    tv[14] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b0};
    tv[15] = '{1'b0, 16'h0000, 4'b1000, 4'h1, 1'b1, 1'b0};
    tv[16] = '{1'b0, 16'h0000, 4'b1000, 4'h1, 1'b1, 1'b0};
    tv[17] = '{1'b0, 16'h0000, 4'b1000, 4'h1, 1'b1, 1'b0};
    tv[18] = '{1'b0, 16'h0000, 4'b1000, 4'h1, 1'b1, 1'b0};
    tv[19] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 1'b1};
    tv[20] = '{1'b0, 16'h0000, 4'b0001, 4'hB, 1'b1, 1'b0};

    rst_n = 1'b0; load = 1'b0; value = '0; zblank_en = 1'b0; blink_en = 1'b0;
    model_reset();
    #2;
    compare('{dsel: 4'b0000, hex: 4'h0, seg: 1'b0, fd: 1'b0, rdy: 1'b1}, "reset");
    check_val("reset_hex", int'(hex), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 1'b0, 1'b0, "idle_dark");

    // 1: first frame of 12AB against hand-written vectors
    foreach (tv[i]) begin
      te = '{dsel: tv[i].dsel, hex: tv[i].hex, seg: tv[i].seg, fd: tv[i].fd, rdy: 1'b1};
      cycle(tv[i].ld, tv[i].val, 1'b0, 1'b0, 1'b1, te, $sformatf("vec%0d", i));
    end
    run(FRAME, 1'b0, 1'b0, "frame2_12ab");

    // 2: leading-zero blanking, then an all-zero value still shows digit 0
    cycle(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, '0, "zb_load");
    run(2 * FRAME, 1'b1, 1'b0, "zb_0005");
    cycle(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, '0, "zero_load");
    run(2 * FRAME, 1'b1, 1'b0, "zb_0000");

    // 3: mid-frame load must not tear the current frame
    run_to_pos(0, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, '0, "load_1234");
    run(2 * FRAME, 1'b0, 1'b0, "show_1234");
    run_to_pos(7, 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, '0, "load_beef");
    check_val("ready_low_after_accept", int'(ready), 0);
    run(2 * FRAME, 1'b0, 1'b0, "show_beef");

    // 4: load held while not ready (including the boundary cycle) is dropped
    cycle(1'b1, 16'h4321, 1'b0, 1'b0, 1'b0, '0, "load_4321");
    for (int i = 0; i < 2 * FRAME && m_pending; i++)
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, '0, "hold_ffff");
    check_val("ready_back", int'(ready), 1);
    run(2 * FRAME, 1'b0, 1'b0, "show_4321");

    // 5: blink
    run(6 * FRAME + 3, 1'b0, 1'b1, "blink");
    run(FRAME, 1'b0, 1'b0, "unblink");

    // 6: async reset during SCAN(2)
    run_to_pos(2 * SLOT + 1, 1'b0, 1'b0);
    check_val("in_scan2", int'(digit_sel), 4);
    rst_n = 1'b0;
    #1;
    compare('{dsel: 4'b0000, hex: 4'h0, seg: 1'b0, fd: 1'b0, rdy: 1'b1}, "midscan_reset");
    check_val("midscan_reset_hex", int'(hex), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(10, 1'b0, 1'b0, "post_reset_dark");
    cycle(1'b1, 16'h00A0, 1'b1, 1'b0, 1'b0, '0, "load_00a0");
    run(FRAME + 2, 1'b1, 1'b0, "show_00a0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
